// File: rtl/sid_clock_reset_sequencer_if.sv
// PLL-side lock input and SID-side clock-enable/reset outputs of the
// SID clock/reset sequencer.
// There is no valid/ready handshake on this bundle: every output is a
// level or a single-cycle pulse. In particular `ready` is a plain status
// level (high while running) and is not a flow-control signal.
interface sid_clock_reset_sequencer_if;
  logic       locked;
  logic       core_reset_n;
  logic       phi2_ce;
  logic       phi2;
  logic       ready;
  logic [1:0] state;
  logic [7:0] lock_loss_count;

  // The sequencer drives the SID side and watches the PLL lock flag.
  modport master (
    input  locked,
    output core_reset_n,
    output phi2_ce,
    output phi2,
    output ready,
    output state,
    output lock_loss_count
  );

  // A consumer (SID core or bench) drives lock and observes the rest.
  modport slave (
    output locked,
    input  core_reset_n,
    input  phi2_ce,
    input  phi2,
    input  ready,
    input  state,
    input  lock_loss_count
  );
endinterface

// File: rtl/sid_clock_reset_sequencer.sv
// SID clock/reset sequencer: qualifies PLL lock, sequences the SID core
// reset and produces the fractional-divided phi2 clock enable.
// Optional feature: define LOCK_LOSS_COUNT_EN to build the saturating
// lock-loss event counter; otherwise lock_loss_count is tied to 0.
module sid_clock_reset_sequencer #(
  parameter int unsigned CLK_HZ             = 50250000,
  parameter int unsigned PHI2_HZ            = 1000000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_TICKS   = 16
) (
  input logic                          clock,
  input logic                          reset_n,
  sid_clock_reset_sequencer_if.master  bus
);

  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(RESET_HOLD_TICKS) + 1;

  localparam logic [31:0]       CLK_U     = 32'(CLK_HZ);
  localparam logic [31:0]       PHI2_U    = 32'(PHI2_HZ);
  localparam logic [31:0]       HALF_U    = 32'(CLK_HZ / 2);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK  = 2'd0,
    S_STABILIZE  = 2'd1,
    S_RESET_HOLD = 2'd2,
    S_RUN        = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, lock_s;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       acc_sum, acc_wrapped;
  logic              acc_wrap, acc_run;
  logic              phi2_ce_q, phi2_ce_d;
  logic              phi2_q, phi2_d;
  logic              core_reset_n_q, ready_q;

  // Two-flop synchronizer for the asynchronous PLL lock flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync1_q <= bus.locked;
      lock_s  <= sync1_q;
    end
  end

  // Phase accumulator step: add PHI2_HZ, wrap by CLK_HZ when it overflows.
  assign acc_sum     = acc_q + PHI2_U;
  assign acc_wrap    = (acc_sum >= CLK_U);
  assign acc_wrapped = acc_wrap ? (acc_sum - CLK_U) : acc_sum;

  // Next-state decode; lock loss always takes priority over progress.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d    = S_STABILIZE;
          stab_cnt_d = '0;
        end
      end
      S_STABILIZE: begin
        if (!lock_s) begin
          state_d    = S_WAIT_LOCK;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d    = S_RESET_HOLD;
          hold_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end
      S_RESET_HOLD: begin
        if (!lock_s) begin
          state_d    = S_WAIT_LOCK;
          hold_cnt_d = '0;
        end else if (phi2_ce_q) begin
          // The pulse currently on phi2_ce is counted here; the last one
          // is still emitted with the core held in reset.
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end
      end
      default: begin
        state_d = S_WAIT_LOCK;
      end
    endcase
  end

  // phi2 generation runs only while staying inside RESET_HOLD/RUN, so the
  // accumulator restarts from 0 on entry and a lock loss suppresses the
  // pulse that would otherwise land in the first WAIT_LOCK cycle.
  always_comb begin
    acc_run   = ((state_q == S_RESET_HOLD) || (state_q == S_RUN)) &&
                ((state_d == S_RESET_HOLD) || (state_d == S_RUN));
    acc_d     = acc_run ? acc_wrapped : '0;
    phi2_ce_d = acc_run & acc_wrap;
    phi2_d    = acc_run & (acc_wrapped >= HALF_U);
  end

  // State, counters, accumulator and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_WAIT_LOCK;
      stab_cnt_q     <= '0;
      hold_cnt_q     <= '0;
      acc_q          <= '0;
      phi2_ce_q      <= 1'b0;
      phi2_q         <= 1'b0;
      core_reset_n_q <= 1'b0;
      ready_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      stab_cnt_q     <= stab_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      acc_q          <= acc_d;
      phi2_ce_q      <= phi2_ce_d;
      phi2_q         <= phi2_d;
      core_reset_n_q <= (state_d == S_RUN);
      ready_q        <= (state_d == S_RUN);
    end
  end

  assign bus.core_reset_n = core_reset_n_q;
  assign bus.ready        = ready_q;
  assign bus.phi2_ce      = phi2_ce_q;
  assign bus.phi2         = phi2_q;
  assign bus.state        = state_q;

`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] lock_loss_q;
  logic       lock_loss_evt;

  assign lock_loss_evt = (state_q != S_WAIT_LOCK) && (state_d == S_WAIT_LOCK);

  // Saturating count of falls back to WAIT_LOCK from any active state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_q <= 8'd0;
    end else if (lock_loss_evt && (lock_loss_q != 8'hFF)) begin
      lock_loss_q <= lock_loss_q + 8'd1;
    end
  end

  assign bus.lock_loss_count = lock_loss_q;
`else
  assign bus.lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_sid_clock_reset_sequencer.sv
// Bench for sid_clock_reset_sequencer: randomized lock waveforms checked
// cycle by cycle against an arithmetic model of the lock/phi2 schedule.
module tb_sid_clock_reset_sequencer;

  localparam int unsigned CLK_HZ  = 50250000;
  localparam int unsigned PHI2_HZ = 1000000;
  localparam int unsigned L_CYC   = 8;
  localparam int unsigned H_TICK  = 2;
  localparam longint P  = PHI2_HZ;
  localparam longint C  = CLK_HZ;
  localparam longint LL = L_CYC;
  localparam longint HH = H_TICK;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   k_hold;

  sid_clock_reset_sequencer_if bus();

  sid_clock_reset_sequencer #(
    .CLK_HZ             (CLK_HZ),
    .PHI2_HZ            (PHI2_HZ),
    .LOCK_STABLE_CYCLES (L_CYC),
    .RESET_HOLD_TICKS   (H_TICK)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // pos_m counts cycles since the synchronized lock last went high
  // (0 means waiting for lock). Everything else is arithmetic on it.
  logic    ls1_m, ls_m;
  longint  pos_m;
  int      llc_m;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ls1_m <= 1'b0;
      ls_m  <= 1'b0;
      pos_m <= 0;
      llc_m <= 0;
    end else begin
      ls1_m <= bus.locked;
      ls_m  <= ls1_m;
      if (ls_m) begin
        pos_m <= pos_m + 1;
      end else begin
        pos_m <= 0;
        if (pos_m != 0 && llc_m < 255) llc_m <= llc_m + 1;
      end
    end
  end

  logic [1:0]  ms;
  logic        mce, mphi;
  longint      mk;
  logic [7:0]  llc_exp;
  logic [13:0] exp_vec, obs_vec;

  always_comb begin
    mk   = pos_m - LL - 1;
    ms   = 2'd0;
    mce  = 1'b0;
    mphi = 1'b0;
    if (pos_m == 0)                             ms = 2'd0;
    else if (pos_m <= LL)                       ms = 2'd1;
    else if (mk >= 1 && ((mk - 1) * P) / C >= HH) ms = 2'd3;
    else                                        ms = 2'd2;
    if (ms >= 2'd2 && mk >= 1) begin
      mce  = ((mk * P) / C) != (((mk - 1) * P) / C);
      mphi = ((mk * P) % C) >= (C / 2);
    end
`ifdef LOCK_LOSS_COUNT_EN
    llc_exp = 8'(llc_m);
`else
    llc_exp = 8'd0;
`endif
    exp_vec = {ms, ms == 2'd3, ms == 2'd3, mce, mphi, llc_exp};
  end

  assign obs_vec = {bus.state, bus.core_reset_n, bus.ready, bus.phi2_ce,
                    bus.phi2, bus.lock_loss_count};

  function automatic int first_pulse_k(longint n);
    longint k = 1;
    while ((k * P) / C < n) k++;
    return int'(k);
  endfunction

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n    = 1'b0;
    bus.locked = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.locked = 1'($urandom_range(0, 1));
      step();
      n_checks++;
      if (obs_vec !== 14'd0) begin
        n_fail++;
        $display("FAIL reset_outputs i=%0d got=%h exp=%h", i, obs_vec, 14'd0);
      end
    end
    bus.locked = 1'b0;
    reset_n    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_release i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_bringup();
    int pulses = 0;
    bus.locked = 1'b1;
    for (int i = 1; i <= 3 + int'(L_CYC) + k_hold + 3; i++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL bringup_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (bus.phi2_ce) pulses++;
      if (i == 2 || i == 3 || i == 2 + int'(L_CYC) || i == 3 + int'(L_CYC)) begin
        n_checks++;
        if (bus.state !== ((i == 2) ? 2'd0 : (i == 3 + int'(L_CYC)) ? 2'd2 : 2'd1)) begin
          n_fail++;
          $display("FAIL bringup_state i=%0d got=%0d", i, bus.state);
        end
      end
      if (i == 3 + int'(L_CYC) + k_hold) begin
        n_checks++;
        if ({bus.phi2_ce, bus.core_reset_n, bus.state} !== 4'b1010) begin
          n_fail++;
          $display("FAIL bringup_last_hold_pulse got=%b exp=1010",
                   {bus.phi2_ce, bus.core_reset_n, bus.state});
        end
      end
      if (i == 4 + int'(L_CYC) + k_hold) begin
        n_checks++;
        if ({bus.core_reset_n, bus.ready, bus.state} !== 4'b1111) begin
          n_fail++;
          $display("FAIL bringup_run_entry got=%b exp=1111",
                   {bus.core_reset_n, bus.ready, bus.state});
        end
      end
    end
    n_checks++;
    if (pulses != int'(H_TICK)) begin
      n_fail++;
      $display("FAIL bringup_pulses got=%0d exp=%0d", pulses, H_TICK);
    end
  endtask

  task automatic test_phi2_rate();
    logic [31:0] exp_q[$];
    logic [31:0] exp_j;
    longint k0 = pos_m - LL - 1;
    int ce_cnt = 0, rises = 0, falls = 0, last = -1, bad_gaps = 0;
    logic prev_phi = bus.phi2;
    for (longint j = 1; j <= 2010; j++)
      if ((((k0 + j) * P) / C) != (((k0 + j - 1) * P) / C)) exp_q.push_back(32'(j));
    for (int j = 1; j <= 2010; j++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rate_model j=%0d got=%h exp=%h", j, obs_vec, exp_vec);
      end
      if (bus.phi2_ce) begin
        ce_cnt++;
        if (last >= 0 && (j - last < 50 || j - last > 51)) bad_gaps++;
        last = j;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rate_extra_pulse got=%0d exp=none", j);
        end else begin
          exp_j = exp_q.pop_front();
          if (exp_j != 32'(j)) begin
            n_fail++;
            $display("FAIL rate_pulse_time got=%0d exp=%0d", j, exp_j);
          end
        end
      end
      if (bus.phi2 && !prev_phi) rises++;
      if (!bus.phi2 && prev_phi) falls++;
      prev_phi = bus.phi2;
    end
    n_checks++;
    if (ce_cnt != 40) begin n_fail++; $display("FAIL rate_count got=%0d exp=40", ce_cnt); end
    n_checks++;
    if (bad_gaps != 0) begin n_fail++; $display("FAIL rate_gaps got=%0d exp=0", bad_gaps); end
    n_checks++;
    if (rises != 40 || falls != 40) begin
      n_fail++;
      $display("FAIL rate_phi2_edges got=%0d/%0d exp=40/40", rises, falls);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rate_missing_pulses got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_lock_loss_run();
    longint kn = pos_m - LL - 1 + 4;
    int wait_n;
    // Drop lock so the first WAIT_LOCK cycle lands on a would-be pulse.
    while (((kn * P) / C) == (((kn - 1) * P) / C)) kn++;
    wait_n = int'(kn - 3 - (pos_m - LL - 1));
    repeat (wait_n) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL loss_pre_model got=%h exp=%h", obs_vec, exp_vec);
      end
    end
    bus.locked = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL loss_pending_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (i == 3) begin
        n_checks++;
        if ({bus.phi2_ce, bus.core_reset_n, bus.ready, bus.state} !== 5'd0) begin
          n_fail++;
          $display("FAIL loss_pending_suppressed got=%b exp=00000",
                   {bus.phi2_ce, bus.core_reset_n, bus.ready, bus.state});
        end
      end
    end
    for (int t = 0; t < 3; t++) begin
      repeat ($urandom_range(3, 10)) begin
        step();
        n_checks++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL loss_low_model t=%0d got=%h exp=%h", t, obs_vec, exp_vec);
        end
      end
      bus.locked = 1'b1;
      repeat (4 + int'(L_CYC) + k_hold + $urandom_range(0, 150)) begin
        step();
        n_checks++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL relock_model t=%0d got=%h exp=%h", t, obs_vec, exp_vec);
        end
      end
      n_checks++;
      if (bus.state !== 2'd3) begin
        n_fail++;
        $display("FAIL relock_run t=%0d got=%0d exp=3", t, bus.state);
      end
      bus.locked = 1'b0;
      for (int i = 1; i <= 3; i++) begin
        step();
        n_checks++;
        if ({bus.core_reset_n, bus.ready, bus.phi2_ce, bus.state} !==
            ((i < 3) ? {2'b11, exp_vec[3], 2'd3} : 5'd0)) begin
          n_fail++;
          $display("FAIL loss_latency t=%0d i=%0d got=%b", t, i,
                   {bus.core_reset_n, bus.ready, bus.phi2_ce, bus.state});
        end
      end
    end
  endtask

  task automatic test_hold_exit_loss();
    repeat (5) step();
    bus.locked = 1'b1;
    for (int i = 1; i <= 3 + int'(L_CYC) + k_hold + 1; i++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL hold_exit_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (i == 3 + int'(L_CYC) + k_hold) begin
        n_checks++;
        if ({bus.phi2_ce, bus.state} !== 3'b110) begin
          n_fail++;
          $display("FAIL hold_exit_pulse got=%b exp=110", {bus.phi2_ce, bus.state});
        end
      end
      if (i == 4 + int'(L_CYC) + k_hold) begin
        n_checks++;
        if ({bus.core_reset_n, bus.ready, bus.state} !== 4'b0000) begin
          n_fail++;
          $display("FAIL hold_exit_loss_wins got=%b exp=0000",
                   {bus.core_reset_n, bus.ready, bus.state});
        end
      end
      if (i == 1 + int'(L_CYC) + k_hold) bus.locked = 1'b0;
    end
  endtask

  task automatic test_stabilize_glitch();
    int llc_before;
    repeat (5) step();
    llc_before = llc_m;
    bus.locked = 1'b1;
    for (int i = 1; i <= 11 + int'(L_CYC) + k_hold; i++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL glitch_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (i == 8 || i == 9 || i == 10 || i == 9 + int'(L_CYC) || i == 10 + int'(L_CYC)) begin
        n_checks++;
        if (bus.state !== ((i == 9) ? 2'd0 : (i == 10 + int'(L_CYC)) ? 2'd2 : 2'd1)) begin
          n_fail++;
          $display("FAIL glitch_state i=%0d got=%0d", i, bus.state);
        end
      end
      if (i == 9) begin
        n_checks++;
`ifdef LOCK_LOSS_COUNT_EN
        if (bus.lock_loss_count !== 8'((llc_before < 255) ? llc_before + 1 : 255)) begin
`else
        if (bus.lock_loss_count !== 8'd0) begin
`endif
          n_fail++;
          $display("FAIL glitch_loss_count got=%0d before=%0d", bus.lock_loss_count, llc_before);
        end
      end
      if (i == 6) bus.locked = 1'b0;
      if (i == 7) bus.locked = 1'b1;
    end
    n_checks++;
    if (bus.state !== 2'd3) begin
      n_fail++;
      $display("FAIL glitch_run got=%0d exp=3", bus.state);
    end
  endtask

  task automatic test_reset_mid_run();
    logic found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (bus.phi2_ce) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL midrun_no_pulse got=0 exp=1");
    end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs_vec !== 14'd0) begin
      n_fail++;
      $display("FAIL midrun_async_clear got=%h exp=%h", obs_vec, 14'd0);
    end
    repeat (3) step();
    reset_n = 1'b1;
    for (int i = 1; i <= 4 + int'(L_CYC) + k_hold; i++) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL midrun_restart_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (i == 2 || i == 3 || i == 3 + int'(L_CYC) || i == 4 + int'(L_CYC) + k_hold) begin
        n_checks++;
        if (bus.state !== ((i == 2) ? 2'd0 : (i == 3) ? 2'd1 :
                           (i == 3 + int'(L_CYC)) ? 2'd2 : 2'd3)) begin
          n_fail++;
          $display("FAIL midrun_restart_state i=%0d got=%0d", i, bus.state);
        end
      end
    end
  endtask

  task automatic test_loss_saturate();
    for (int n = 0; n < 300; n++) begin
      bus.locked = 1'b1;
      repeat (4) begin
        step();
        n_checks++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL sat_model n=%0d got=%h exp=%h", n, obs_vec, exp_vec);
        end
      end
      bus.locked = 1'b0;
      repeat (4) begin
        step();
        n_checks++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL sat_model n=%0d got=%h exp=%h", n, obs_vec, exp_vec);
        end
      end
    end
    n_checks++;
`ifdef LOCK_LOSS_COUNT_EN
    if (bus.lock_loss_count !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_count got=%0d exp=255", bus.lock_loss_count);
    end
`else
    if (bus.lock_loss_count !== 8'd0) begin
      n_fail++;
      $display("FAIL sat_count got=%0d exp=0", bus.lock_loss_count);
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    k_hold = first_pulse_k(HH);
    test_reset();
    test_bringup();
    test_phi2_rate();
    test_lock_loss_run();
    test_hold_exit_loss();
    test_stabilize_glitch();
    test_reset_mid_run();
    test_loss_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sid_clock_reset_sequencer.md
Name: sid_clock_reset_sequencer

Overview:
Consumer end of the iCE40 PLL output. It takes the PLL `locked` flag and the PLL clock, qualifies lock stability, and sequences the SID core reset. It also generates the fractional-divided phi2 clock-enable (about 1 MHz from 50.25 MHz) that drives the MOS6581 core. It sits between the PLL wrapper and the SID core, and every SID register/oscillator enable is derived from its outputs.

Parameters:
CLK_HZ, 50250000, frequency of `clock` in Hz (PLL achieved output)
PHI2_HZ, 1000000, target phi2 enable rate in Hz; must be < CLK_HZ/2
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before reset sequencing
RESET_HOLD_TICKS, 16, phi2_ce pulses during which core_reset_n is held low with phi2 running

Ports:
clock  input  1  PLL output clock, single clock domain
reset_n  input  1  asynchronous active-low reset
locked  input  1  PLL LOCK, asynchronous to clock
core_reset_n  output  1  registered active-low reset to SID core
phi2_ce  output  1  one-cycle clock-enable pulse at PHI2_HZ average rate
phi2  output  1  registered phi2 level (~50% duty) for external bus timing
ready  output  1  high in S_RUN
state  output  2  FSM state: 0 WAIT_LOCK, 1 STABILIZE, 2 RESET_HOLD, 3 RUN
lock_loss_count  output  8  lock-loss event count (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-low on `reset_n`, single clock `clock`. While reset_n=0: all outputs are 0, state=WAIT_LOCK, synchronizer/counters/accumulator are 0.
- `locked` passes through a 2-flop synchronizer (reset to 0) to give `lock_s`. All FSM decisions use `lock_s`.
- Phase accumulator, 32-bit unsigned: `acc_next = acc + PHI2_HZ`. If `acc_next >= CLK_HZ`, then `acc <= acc_next - CLK_HZ` and `phi2_ce <= 1`; otherwise `phi2_ce <= 0`.
  - Runs only in RESET_HOLD and RUN. In other states acc=0, phi2_ce=0, phi2=0.
  - Defaults give exactly 4 pulses per 201 cycles, spacing 50 or 51 cycles, never 49 or 52.
- `phi2 <= (acc_next_wrapped >= CLK_HZ/2)`, registered. It is 0 outside RESET_HOLD/RUN.
- FSM:
  - WAIT_LOCK: core_reset_n=0. If lock_s=1, go to STABILIZE with stab_cnt=0.
  - STABILIZE: stab_cnt increments each cycle lock_s=1. If lock_s=0, go to WAIT_LOCK and clear stab_cnt. When stab_cnt reaches LOCK_STABLE_CYCLES-1, go to RESET_HOLD with hold_cnt=0 and acc=0.
  - RESET_HOLD: core_reset_n=0, phi2_ce active, hold_cnt increments on each phi2_ce. When the phi2_ce pulse that brings hold_cnt to RESET_HOLD_TICKS is emitted, go to RUN. If lock_s=0, go to WAIT_LOCK.
  - RUN: core_reset_n=1, ready=1. If lock_s=0, go to WAIT_LOCK.
- Outputs are registered from the next-state decode:
  - core_reset_n and ready rise in the first RUN cycle.
  - On lock loss, core_reset_n, ready and phi2_ce are all 0 in the first cycle with state=WAIT_LOCK, which is 3 cycles after `locked` falls. No phi2_ce pulse is emitted in that cycle.
- Lock loss in the same cycle as a pending phi2_ce: lock loss wins, the pulse is suppressed.
- Lock loss in the same cycle as the RESET_HOLD→RUN transition: lock loss wins, next state is WAIT_LOCK.
- A lock-loss event is a transition to WAIT_LOCK from STABILIZE, RESET_HOLD or RUN.
- Counter widths are $clog2 of their limits plus 1; none wrap.

Optional Feature:
Macro LOCK_LOSS_COUNT_EN.
- Defined: lock_loss_count is an 8-bit counter, reset to 0, +1 per lock-loss event, saturating at 255.
- Undefined: the counter logic is absent and lock_loss_count is driven constant 0.

Test Plan:
- Params LOCK_STABLE_CYCLES=8, RESET_HOLD_TICKS=2; reset_n low 5 cycles, then high; locked=1 from cycle 10 → state 1 from cycle 13, state 2 from cycle 21, core_reset_n=1 and ready=1 after the 2nd phi2_ce; state=3.
- Defaults, RUN for 2010 cycles → exactly 40 phi2_ce pulses, every gap 50 or 51, phi2 toggles 40 times per direction.
- STABILIZE with locked pulsed low 1 cycle at stab_cnt=5 → return to WAIT_LOCK, stab_cnt restarts at 0, RESET_HOLD entry delayed accordingly; lock_loss_count=1 with macro, 0 without.
- RUN, locked drops → core_reset_n=0, ready=0, phi2_ce=0 exactly 3 cycles later; relock repeats the full sequence.
- reset_n asserted mid-RUN during a phi2_ce cycle → all outputs 0 immediately (asynchronously); after release, sequence restarts from WAIT_LOCK.
- Macro defined, 300 lock-loss events → lock_loss_count holds 255.
